ppu_quant: RTL and testbench

PPU_QUANT -- requirements
Module: ppu_quant

---
 rtl/ppu_quant_if.sv | 23 ++
 rtl/ppu_quant.sv | 126 ++++++++++++
 tb/tb_ppu_quant.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_quant_if.sv
// Row stream from the PPU quantizer to its consumer.
// master: valid/data/row/last out, ready in; slave: the reverse.
interface ppu_quant_if #(
  parameter int LANES = 16,
  parameter int OUT_W = 8,
  parameter int ROWS  = 16
);
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*OUT_W-1:0]  out_data;
  logic [$clog2(ROWS)-1:0] out_row;
  logic                    out_last;

  modport master (
    output out_valid, out_data, out_row, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_last,
    output out_ready
  );
endinterface

// File: rtl/ppu_quant.sv
// PPU requantizer: captures a 16-row accumulator tile, quantizes
// each lane, buffers rows and drains them over a ready/valid stream.
// Ports: clk, rst (sync, active-high), ppu_start, ppu_in (row),
// shift_amt, relu_en, q (row stream), busy, done, err_overlap.
module ppu_quant #(
  parameter int LANES = 16,
  parameter int ACC_W = 24,
  parameter int ROWS  = 16,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ppu_start,
  input  logic [LANES*ACC_W-1:0] ppu_in,
  input  logic [4:0]             shift_amt,
  input  logic                   relu_en,
  ppu_quant_if.master            q,
  output logic                   busy,
  output logic                   done,
  output logic                   err_overlap
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = RW + 1;
  localparam int DW = LANES * OUT_W;
  localparam int W  = ACC_W + 2;
  localparam logic [4:0] SH_MAX = 5'(ACC_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t          state;
  logic [RW-1:0]   rd_ptr;
  logic [CW-1:0]   wr_cnt;
  logic [4:0]      sh;
  logic            relu;
  logic [DW-1:0]   rowbuf [ROWS];
  logic [DW-1:0]   qrow;
  logic            hs;

  function automatic logic [OUT_W-1:0] quant(
    input logic [ACC_W-1:0] a,
    input logic [4:0]       s,
    input logic             r
  );
    logic signed [W-1:0] v;
    logic signed [W-1:0] rnd;
    v   = {{2{a[ACC_W-1]}}, a};
    rnd = '0;
    if (s != 5'd0) rnd = W'(1) << (s - 5'd1);
    v = (v + rnd) >>> s;
    if (r && v[W-1]) v = '0;
    // fits when all bits above the output sign match it
    if (&v[W-1:OUT_W-1] || ~|v[W-1:OUT_W-1])
      quant = v[OUT_W-1:0];
    else if (v[W-1])
      quant = {1'b1, {(OUT_W-1){1'b0}}};
    else
      quant = {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    qrow = '0;
    for (int i = 0; i < LANES; i++)
      qrow[i*OUT_W +: OUT_W] =
        quant(ppu_in[i*ACC_W +: ACC_W], sh, relu);
  end

  assign busy        = (state != IDLE);
  assign q.out_valid = busy && ({1'b0, rd_ptr} < wr_cnt);
  assign q.out_data  = q.out_valid ? rowbuf[rd_ptr] : '0;
  assign q.out_row   = rd_ptr;
  assign q.out_last  = q.out_valid
                    && (rd_ptr == RW'(ROWS - 1));
  assign hs          = q.out_valid && q.out_ready;

  always_ff @(posedge clk) begin
    if (state == CAPTURE)
      rowbuf[wr_cnt[RW-1:0]] <= qrow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_cnt      <= '0;
      sh          <= '0;
      relu        <= 1'b0;
      done        <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ppu_start && busy) err_overlap <= 1'b1;
      unique case (state)
        IDLE: begin
          if (ppu_start) begin
            state  <= CAPTURE;
            sh     <= (shift_amt > SH_MAX) ? SH_MAX
                                           : shift_amt;
            relu   <= relu_en;
            wr_cnt <= '0;
            rd_ptr <= '0;
          end
        end
        CAPTURE: begin
          wr_cnt <= wr_cnt + 1'b1;
          if (wr_cnt == CW'(ROWS - 1)) state <= DRAIN;
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase
      // the final handshake wins over the capture transition
      if (hs) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_ptr == RW'(ROWS - 1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_quant.sv
// Testbench for ppu_quant: behavioural tile model with a per-cycle
// compare process, plus directed tiles with literal expectations.
module tb_ppu_quant;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ppu_start = 1'b0;
  logic         relu_en = 1'b0;
  logic [383:0] ppu_in = '0;
  logic [4:0]   shift_amt = '0;
  logic         busy, done, err_overlap;

  ppu_quant_if q_if ();

  ppu_quant dut (
    .clk         (clk),
    .rst         (rst),
    .ppu_start   (ppu_start),
    .ppu_in      (ppu_in),
    .shift_amt   (shift_amt),
    .relu_en     (relu_en),
    .q           (q_if),
    .busy        (busy),
    .done        (done),
    .err_overlap (err_overlap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int rowdat[16][16];
  int rdy_on = 0;
  bit chk_en = 1'b0;

  logic [127:0] m_rows[16];
  int m_cap = 0, m_del = 0, m_sh = 0;
  bit m_busy = 0, m_done = 0, m_err = 0, m_rl = 0;

  int log_base = 0;
  int pres_cyc[16];
  logic [127:0] pres_data[16];
  int last_cnt, last_cyc, done_cnt, done_cyc, fall_cyc;
  bit prev_busy = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] qref(input int x,
                                      input int s,
                                      input bit r);
    int v;
    v = x;
    if (s > 0) v = v + (1 << (s - 1));
    v = v >>> s;
    if (r && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [127:0] qrow_ref(
    input logic [383:0] r);
    logic [127:0] o;
    int x;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      x = $signed(r[i*24 +: 24]);
      o[i*8 +: 8] = qref(x, m_sh, m_rl);
    end
    return o;
  endfunction

  function automatic logic [383:0] pack(input int k);
    logic [383:0] v;
    int t;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      t = rowdat[k][i];
      v[i*24 +: 24] = t[23:0];
    end
    return v;
  endfunction

  // tile model: 16 rows captured after the start, delivered in order
  always @(posedge clk) begin : model
    bit pb, hs;
    if (rst) begin
      m_busy = 0; m_cap = 0; m_del = 0; m_done = 0;
      m_err = 0; m_sh = 0; m_rl = 0;
    end else begin
      pb = m_busy;
      hs = m_busy && (m_del < m_cap) && q_if.out_ready;
      m_done = 0;
      if (pb && m_cap < 16) begin
        m_rows[m_cap] = qrow_ref(ppu_in);
        m_cap++;
      end
      if (hs) begin
        m_del++;
        if (m_del == 16) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (ppu_start) begin
        if (pb) m_err = 1;
        else begin
          m_busy = 1; m_cap = 0; m_del = 0;
          m_sh = (shift_amt > 23) ? 23 : int'(shift_amt);
          m_rl = relu_en;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit mv;
    if (chk_en) begin
      mv = m_busy && (m_del < m_cap);
      chk("out_valid", q_if.out_valid, mv);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err_overlap", err_overlap, m_err);
      chk("out_last", q_if.out_last, mv && m_del == 15);
      if (mv) begin
        chk("out_data", q_if.out_data, m_rows[m_del]);
        chk("out_row", q_if.out_row, m_del);
      end
      if (cyc > log_base) begin
        if (q_if.out_valid && q_if.out_ready) begin
          pres_cyc[q_if.out_row] = cyc;
          pres_data[q_if.out_row] = q_if.out_data;
        end
        if (q_if.out_last) begin
          last_cnt++;
          last_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (prev_busy && !busy) fall_cyc = cyc;
      end
      prev_busy = busy;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    q_if.out_ready = (cyc >= rdy_on);
  endtask

  task automatic drive_tile(input int sh, input bit rl,
                            input int rdy_off,
                            input int xs_off,
                            input int rst_off,
                            output int n);
    n = cyc;
    log_base = n;
    for (int k = 0; k < 16; k++) pres_cyc[k] = -1;
    last_cnt = 0; last_cyc = -1;
    done_cnt = 0; done_cyc = -1; fall_cyc = -1;
    rdy_on = n + rdy_off;
    q_if.out_ready = (cyc >= rdy_on);
    ppu_start = 1'b1;
    shift_amt = 5'(sh);
    relu_en = rl;
    tick;
    ppu_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ppu_in = pack(k);
      ppu_start = (cyc == n + xs_off);
      if (cyc == n + xs_off) begin
        shift_amt = 5'd7;
        relu_en = ~rl;
      end
      rst = (cyc == n + rst_off);
      if (rst_off > 0 && cyc == n + rst_off + 1) begin
        @(negedge clk);
        chk("rst_valid", q_if.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_overlap, 0);
        chk("rst_data", q_if.out_data, 0);
        chk("rst_row", q_if.out_row, 0);
      end
      tick;
    end
    ppu_start = 1'b0;
    rst = 1'b0;
    ppu_in = '0;
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while ((busy || m_busy) && t < 100) begin
      tick;
      t++;
    end
    chk("idle_timeout", t < 100, 1);
    tick;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b;
    q_if.out_ready = 1'b1;
    repeat (2) tick;
    @(negedge clk);
    chk("reset_valid", q_if.out_valid, 0);
    chk("reset_data", q_if.out_data, 0);
    chk("reset_row", q_if.out_row, 0);
    chk("reset_last", q_if.out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err_overlap, 0);
    tick;
    rst = 1'b0;
    chk_en = 1'b1;

    // row k = k everywhere, always ready
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 16; i++) rowdat[k][i] = k;
    drive_tile(0, 0, 0, -1, -1, n);
    wait_idle;
    for (int k = 0; k < 16; k++) begin
      b = 8'(k);
      chk("t1_cycle", pres_cyc[k], n + 2 + k);
      chk("t1_data", pres_data[k], {16{b}});
    end
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_last_cyc", last_cyc, n + 17);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, n + 18);
    chk("t1_busy_fall", fall_cyc, n + 18);

    // saturation
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 16; i++)
        rowdat[k][i] = k * 1000 - i * 500;
    rowdat[0][0] = 256;  rowdat[0][1] = 127;
    rowdat[0][2] = -1000; rowdat[0][3] = -128;
    drive_tile(0, 0, 0, -1, -1, n);
    wait_idle;
    chk("t2_sat", pres_data[0][31:0], 32'h80807F7F);

    // rounding, shift 4
    rowdat[0][0] = 24;  rowdat[0][1] = 23;
    rowdat[0][2] = -24; rowdat[0][3] = -25;
    drive_tile(4, 0, 0, -1, -1, n);
    wait_idle;
    chk("t3_round", pres_data[0][31:0], 32'hFEFF0102);

    // relu
    rowdat[0][0] = -5; rowdat[0][1] = 9;
    drive_tile(0, 1, 0, -1, -1, n);
    wait_idle;
    chk("t4_relu", pres_data[0][15:0], 16'h0900);

    // shift 31 clamps to 23
    rowdat[0][0] = 8388607; rowdat[0][1] = -8388608;
    rowdat[0][2] = 4194304; rowdat[0][3] = 4194303;
    drive_tile(31, 0, 0, -1, -1, n);
    wait_idle;
    chk("t5_clamp", pres_data[0][31:0], 32'h0001FF01);

    // backpressure until N+30
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 16; i++)
        rowdat[k][i] = (k * 37 + i * 113) % 2000 - 1000;
    drive_tile(1, 0, 30, -1, -1, n);
    wait_idle;
    for (int k = 0; k < 16; k++)
      chk("t6_cycle", pres_cyc[k], n + 30 + k);
    chk("t6_done_cyc", done_cyc, n + 46);
    chk("t6_done_cnt", done_cnt, 1);

    // overlapping start at N+5
    drive_tile(2, 0, 0, 5, -1, n);
    wait_idle;
    chk("t7_err", err_overlap, 1);
    chk("t7_done_cnt", done_cnt, 1);
    chk("t7_done_cyc", done_cyc, n + 18);
    chk("t7_row15", pres_cyc[15], n + 17);

    // reset mid-tile at N+8
    drive_tile(0, 1, 0, -1, 8, n);
    repeat (4) tick;
    chk("t8_no_done", done_cnt, 0);
    chk("t8_busy", busy, 0);

    // recovery tile after reset
    drive_tile(3, 1, 0, -1, -1, n);
    wait_idle;
    chk("t9_done_cyc", done_cyc, n + 18);

    repeat (2) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
